// File: rtl/writeback_stage.sv
// Register-file write-port driver: merges execute results with load returns.
// Loads are extended at enqueue and buffered; outputs are registered.
module writeback_stage #(
    parameter int LOAD_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ex_valid,
    input  logic [4:0]                    ex_rd,
    input  logic [31:0]                   ex_value,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [4:0]                    ld_rd,
    input  logic [2:0]                    ld_funct3,
    input  logic [1:0]                    ld_offset,
    input  logic [31:0]                   ld_data,
    output logic [4:0]                    write_address,
    output logic [31:0]                   write_value,
    output logic [31:0]                   load_pending,
    output logic [$clog2(LOAD_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(LOAD_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(LOAD_DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
    } ld_ent_t;

    ld_ent_t               mem [LOAD_DEPTH];
    logic [LOAD_DEPTH-1:0] occ;
    logic [LOAD_DEPTH-1:0] occ_n;
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic                  live;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ext_value;
    logic [31:0]           pend_n;
    logic [4:0]            ent_rd;

    // live holds ready low until the first edge after reset release
    assign ld_ready = live && (fifo_count != FULL);
    assign accept   = ld_valid && ld_ready;
    assign push     = accept && (ld_rd != 5'd0);
    assign pop      = !ex_valid && (fifo_count != '0);

    always_comb begin
        ld_byte = ld_data[8*ld_offset +: 8];
        ld_half = ld_offset[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_funct3)
            3'b000:  ext_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ext_value = {{16{ld_half[15]}}, ld_half};
            3'b100:  ext_value = {24'd0, ld_byte};
            3'b101:  ext_value = {16'd0, ld_half};
            default: ext_value = ld_data;
        endcase
    end

    // Pending mask is computed from next-state occupancy so it stays a flop
    always_comb begin
        occ_n  = occ;
        pend_n = '0;
        ent_rd = '0;
        if (pop) begin
            occ_n[rptr] = 1'b0;
        end
        if (push) begin
            occ_n[wptr] = 1'b1;
        end
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            ent_rd = (push && wptr == AW'(i)) ? ld_rd : mem[i].rd;
            if (occ_n[i]) begin
                pend_n[ent_rd] = 1'b1;
            end
        end
        pend_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{rd: ld_rd, value: ext_value};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live          <= 1'b0;
            occ           <= '0;
            wptr          <= '0;
            rptr          <= '0;
            fifo_count    <= '0;
            load_pending  <= '0;
            write_address <= '0;
            write_value   <= '0;
        end else begin
            live         <= 1'b1;
            occ          <= occ_n;
            load_pending <= pend_n;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (ex_valid) begin
                write_address <= ex_rd;
                write_value   <= ex_value;
            end else if (pop) begin
                write_address <= mem[rptr].rd;
                write_value   <= mem[rptr].value;
            end else begin
                write_address <= '0;
                write_value   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_writeback_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_value;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic [31:0] ld_data;
    logic [4:0]  write_address;
    logic [31:0] write_value;
    logic [31:0] load_pending;
    logic [$clog2(DEPTH):0] fifo_count;

    writeback_stage #(.LOAD_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_value      (ex_value),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_funct3     (ld_funct3),
        .ld_offset     (ld_offset),
        .ld_data       (ld_data),
        .write_address (write_address),
        .write_value   (write_value),
        .load_pending  (load_pending),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned rd;
        int unsigned value;
    } ent_t;

    ent_t        q[$];
    int unsigned m_addr;
    int unsigned m_value;
    bit          m_live;
    int          n_checks;
    int          n_errors;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ref_ext(int unsigned f, int unsigned off,
                                            int unsigned d);
        int unsigned b;
        int unsigned h;
        b = (d >> (8 * off)) % 256;
        h = (d >> (16 * (off / 2))) % 65536;
        case (f)
            0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4: return b;
            5: return h;
            default: return d;
        endcase
    endfunction

    function automatic int unsigned ref_pending();
        int unsigned p;
        p = 0;
        foreach (q[i]) p = p | (32'd1 << q[i].rd);
        return p;
    endfunction

    function automatic bit ref_ready();
        return m_live && (q.size() < DEPTH);
    endfunction

    task automatic compare_all();
        chk("addr", 32'(write_address), m_addr);
        chk("value", write_value, m_value);
        chk("pending", load_pending, ref_pending());
        chk("count", 32'(fifo_count), q.size());
        chk("ready", 32'(ld_ready), 32'(ref_ready()));
    endtask

    // Advance model and DUT by one clock using the currently driven inputs
    task automatic tick();
        bit   acc;
        ent_t e;
        acc = ld_valid && ref_ready();
        if (ex_valid) begin
            m_addr  = ex_rd;
            m_value = ex_value;
        end else if (q.size() > 0) begin
            e       = q.pop_front();
            m_addr  = e.rd;
            m_value = e.value;
        end else begin
            m_addr  = 0;
            m_value = 0;
        end
        if (acc && ld_rd != 0) begin
            e.rd    = ld_rd;
            e.value = ref_ext(ld_funct3, ld_offset, ld_data);
            q.push_back(e);
        end
        m_live = 1'b1;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        ex_valid  = 1'b0;
        ex_rd     = '0;
        ex_value  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_funct3 = '0;
        ld_offset = '0;
        ld_data   = '0;
    endtask

    task automatic do_reset(int cycles);
        reset_n = 1'b0;
        q.delete();
        m_addr  = 0;
        m_value = 0;
        m_live  = 1'b0;
        #1;
        compare_all();
        repeat (cycles) @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;
    endtask

    task automatic load(int unsigned rd, int unsigned f, int unsigned off,
                        logic [31:0] d);
        ld_valid  = 1'b1;
        ld_rd     = 5'(rd);
        ld_funct3 = 3'(f);
        ld_offset = 2'(off);
        ld_data   = d;
    endtask

    task automatic ext_case(string tag, int unsigned f, int unsigned off,
                            logic [31:0] exp);
        load(9, f, off, 32'h8070_F0A5);
        tick();
        ld_valid = 1'b0;
        tick();
        chk({tag, "_addr"}, 32'(write_address), 32'd9);
        chk(tag, write_value, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset_n = 1'b0;
        m_live  = 1'b0;
        #12;
        do_reset(2);
        tick();
        chk("ready_after_reset", 32'(ld_ready), 32'd1);

        // Execute passthrough
        ex_valid = 1'b1;
        ex_rd    = 5'd5;
        ex_value = 32'hDEAD_BEEF;
        tick();
        chk("ex_addr", 32'(write_address), 32'd5);
        chk("ex_value", write_value, 32'hDEAD_BEEF);
        ex_rd = 5'd0;
        tick();
        chk("ex_x0", 32'(write_address), 32'd0);
        ex_valid = 1'b0;
        tick();

        // Load extension
        ext_case("lb1", 0, 1, 32'hFFFF_FFF0);
        ext_case("lbu3", 4, 3, 32'h0000_0080);
        ext_case("lh2", 1, 2, 32'hFFFF_8070);
        ext_case("lhu0", 5, 0, 32'h0000_F0A5);
        ext_case("lw", 2, 0, 32'h8070_F0A5);
        ext_case("f111", 7, 1, 32'h8070_F0A5);
        tick();

        // Priority and full
        ex_valid = 1'b1;
        ex_rd    = 5'd1;
        ex_value = 32'h1111_1111;
        load(3, 2, 0, 32'h0000_0333);
        tick();
        load(7, 2, 0, 32'h0000_0777);
        tick();
        ld_valid = 1'b0;
        tick();
        chk("full_count", 32'(fifo_count), 32'd2);
        chk("full_ready", 32'(ld_ready), 32'd0);
        chk("full_pending", load_pending, 32'h88);
        chk("full_ex_addr", 32'(write_address), 32'd1);
        ex_valid = 1'b0;
        tick();
        chk("drain_x3", 32'(write_address), 32'd3);
        chk("drain_pend1", load_pending, 32'h80);
        tick();
        chk("drain_x7", 32'(write_address), 32'd7);
        chk("drain_pend0", load_pending, 32'h0);
        tick();

        // Simultaneous push and pop at count 1
        load(4, 2, 0, 32'h0000_0444);
        tick();
        load(5, 2, 0, 32'h0000_0555);
        tick();
        chk("pp_ready", 32'(ld_ready), 32'd1);
        chk("pp_count", 32'(fifo_count), 32'd1);
        chk("pp_x4", 32'(write_address), 32'd4);
        ld_valid = 1'b0;
        tick();
        chk("pp_x5", 32'(write_address), 32'd5);
        tick();

        // Wrap: ten back-to-back loads
        for (int i = 1; i <= 10; i++) begin
            load(i, 2, 0, 32'(i * 32'h0101_0101));
            tick();
            if (i >= 2) chk("wrap_addr", 32'(write_address), 32'(i - 1));
        end
        ld_valid = 1'b0;
        tick();
        chk("wrap_last", 32'(write_address), 32'd10);
        chk("wrap_last_val", write_value, 32'h0A0A_0A0A);
        tick();

        // Reset mid-stream with two loads queued
        ex_valid = 1'b1;
        ex_rd    = 5'd2;
        load(12, 2, 0, 32'h0000_0CCC);
        tick();
        load(13, 2, 0, 32'h0000_0DDD);
        tick();
        ld_valid = 1'b0;
        idle_inputs();
        ex_valid = 1'b1;
        #2;
        do_reset(3);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_nowrite", 32'(write_address), 32'd0);
        end
        chk("rst_ready_after", 32'(ld_ready), 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            ex_valid  = ($urandom_range(0, 99) < 30);
            ex_rd     = 5'($urandom);
            ex_value  = $urandom;
            ld_valid  = ($urandom_range(0, 99) < 60);
            ld_rd     = 5'($urandom);
            ld_funct3 = 3'($urandom);
            ld_offset = 2'($urandom);
            ld_data   = $urandom;
            if (n == 1500) begin
                #2;
                do_reset(2);
            end
            tick();
        end

        idle_inputs();
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
